// File: rtl/soc_system_sysid_checker.sv
// rtl/soc_system_sysid_checker.sv - Avalon-MM reader that checks system ID and build timestamp
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h591C4BB7,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          USE_READDATAVALID  = 1'b1,
  parameter bit          AUTO_START         = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS, S_DONE
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        auto_pend, auto_pend_n;
  logic        pass_n, id_mm_n, ts_mm_n, to_n;
  logic [31:0] cap_id_n, cap_ts_n;

  logic rd_phase, ts_phase, accept, got_data, expired;

  assign rd_phase = (state == S_RD_ID) || (state == S_RD_TS);
  assign ts_phase = (state == S_RD_TS) || (state == S_WT_TS);
  assign accept   = rd_phase && !avm_waitrequest;
  // Data may arrive with the accept itself: always without readdatavalid,
  // or when the slave answers in the same cycle.
  assign got_data = rd_phase ? (accept && (!USE_READDATAVALID || avm_readdatavalid))
                             : ((state == S_WT_ID || state == S_WT_TS) && avm_readdatavalid);
  assign expired  = (cnt + 16'd1) >= TMO;

  assign avm_read    = rd_phase;
  assign avm_address = (state == S_RD_TS);
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    auto_pend_n = auto_pend;
    pass_n      = pass;
    id_mm_n     = id_mismatch;
    ts_mm_n     = ts_mismatch;
    to_n        = timeout;
    cap_id_n    = captured_id;
    cap_ts_n    = captured_ts;

    case (state)
      S_IDLE: begin
        if (start || auto_pend) begin
          state_n     = S_RD_ID;
          auto_pend_n = 1'b0;
          cnt_n       = 16'd0;
          pass_n      = 1'b0;
          id_mm_n     = 1'b0;
          ts_mm_n     = 1'b0;
          to_n        = 1'b0;
          cap_id_n    = 32'd0;
          cap_ts_n    = 32'd0;
        end
      end
      S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS: begin
        cnt_n = cnt + 16'd1;
        if (got_data) begin
          cnt_n = 16'd0;
          if (ts_phase) begin
            cap_ts_n = avm_readdata;
            ts_mm_n  = (avm_readdata != EXPECTED_TIMESTAMP);
            state_n  = S_DONE;
          end else begin
            cap_id_n = avm_readdata;
            id_mm_n  = (avm_readdata != EXPECTED_ID);
            state_n  = S_RD_TS;
          end
        end else if (accept) begin
          state_n = ts_phase ? S_WT_TS : S_WT_ID;
        end else if (expired) begin
          to_n    = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // pass becomes visible together with the done pulse
    if (state_n == S_DONE && state != S_DONE)
      pass_n = !id_mm_n && !ts_mm_n && !to_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      auto_pend   <= AUTO_START;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      auto_pend   <= auto_pend_n;
      pass        <= pass_n;
      id_mismatch <= id_mm_n;
      ts_mismatch <= ts_mm_n;
      timeout     <= to_n;
      captured_id <= cap_id_n;
      captured_ts <= cap_ts_n;
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// tb/tb_soc_system_sysid_checker.sv - directed bench for the sysid checker
module tb_soc_system_sysid_checker;

  localparam logic [31:0] ID = 32'hACD51302;
  localparam logic [31:0] TS = 32'h591C4BB7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_address, avm_read, busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] captured_id, captured_ts;

  logic        reset2 = 1'b1;
  logic        avm_address2, avm_read2, busy2, done2, pass2, id_mm2, ts_mm2, timeout2;
  logic [31:0] captured_id2, captured_ts2, rdata2;

  always #5 clock = ~clock;

  soc_system_sysid_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout(timeout),
    .captured_id(captured_id), .captured_ts(captured_ts)
  );

  // combinational zero-wait slave for the auto-start, no-readdatavalid variant
  assign rdata2 = avm_address2 ? TS : ID;

  soc_system_sysid_checker #(.USE_READDATAVALID(1'b0), .AUTO_START(1'b1)) dut2 (
    .clock(clock), .reset(reset2), .start(1'b0),
    .avm_address(avm_address2), .avm_read(avm_read2),
    .avm_waitrequest(1'b0), .avm_readdata(rdata2),
    .avm_readdatavalid(1'b1),
    .busy(busy2), .done(done2), .pass(pass2),
    .id_mismatch(id_mm2), .ts_mismatch(ts_mm2), .timeout(timeout2),
    .captured_id(captured_id2), .captured_ts(captured_ts2)
  );

  int total = 0;
  int bad = 0;

  int   done_at, busy_cyc, done_cnt, acc_cnt;
  logic acc_addr [0:3];
  bit   stable_ok;
  logic read_at_done;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Slave model driven at each negedge; ws = wait cycles per read
  task automatic serve(input int ws, input logic [31:0] idv, input logic [31:0] tsv,
                       input bit drop_id, input bit poke_start, input int ncyc);
    bit          pend = 1'b0;
    logic [31:0] pdata = 32'd0;
    int          stall = 0;
    bit          prev_stall = 1'b0;
    logic        prev_addr = 1'b0;
    done_at = -1; busy_cyc = 0; done_cnt = 0; acc_cnt = 0; stable_ok = 1'b1;
    read_at_done = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      if (prev_stall && (avm_read !== 1'b1 || avm_address !== prev_addr)) stable_ok = 1'b0;
      avm_readdatavalid = pend;
      avm_readdata = pend ? pdata : 32'h0BAD0BAD;
      pend = 1'b0;
      prev_stall = 1'b0;
      start = poke_start && (c == 1 || c == 2);
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = c; read_at_done = avm_read; end
      end
      if (avm_read === 1'b1) begin
        if (stall < ws) begin
          avm_waitrequest = 1'b1; stall++; prev_stall = 1'b1; prev_addr = avm_address;
        end else begin
          avm_waitrequest = 1'b0; stall = 0;
          if (acc_cnt < 4) acc_addr[acc_cnt] = avm_address;
          acc_cnt++;
          if (!(drop_id && avm_address == 1'b0)) begin
            pend = 1'b1; pdata = avm_address ? tsv : idv;
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      @(negedge clock);
    end
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++; if ({avm_read, avm_address, busy, done, pass, id_mismatch, ts_mismatch, timeout} !== 8'd0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000000",
        {avm_read, avm_address, busy, done, pass, id_mismatch, ts_mismatch, timeout}); end
    total++; if ({captured_id, captured_ts} !== 64'd0) begin
      bad++; $display("FAIL reset_captures: got %h want 0", {captured_id, captured_ts}); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_auto: busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    pulse_start();
    serve(0, ID, TS, 1'b0, 1'b0, 10);
    total++; if (done_at !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", done_at); end
    total++; if (busy_cyc !== 4) begin bad++; $display("FAIL basic_busy: got %0d want 4", busy_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    total++; if (acc_cnt !== 2 || acc_addr[0] !== 1'b0 || acc_addr[1] !== 1'b1) begin
      bad++; $display("FAIL basic_addrs: got n=%0d a0=%b a1=%b want n=2 a0=0 a1=1", acc_cnt, acc_addr[0], acc_addr[1]); end
    total++; if ({pass, id_mismatch, ts_mismatch, timeout} !== 4'b1000) begin
      bad++; $display("FAIL basic_flags: got %b want 1000", {pass, id_mismatch, ts_mismatch, timeout}); end
    total++; if (captured_id !== ID || captured_ts !== TS) begin
      bad++; $display("FAIL basic_captures: got %h %h want %h %h", captured_id, captured_ts, ID, TS); end
  endtask

  task automatic test_id_mismatch();
    pulse_start();
    serve(0, 32'h00000000, TS, 1'b0, 1'b0, 10);
    total++; if ({pass, id_mismatch, ts_mismatch, timeout} !== 4'b0100) begin
      bad++; $display("FAIL idmm_flags: got %b want 0100", {pass, id_mismatch, ts_mismatch, timeout}); end
    total++; if (acc_cnt !== 2 || acc_addr[1] !== 1'b1) begin
      bad++; $display("FAIL idmm_ts_read: got n=%0d a1=%b want n=2 a1=1", acc_cnt, acc_addr[1]); end
    total++; if (captured_id !== 32'd0 || captured_ts !== TS) begin
      bad++; $display("FAIL idmm_captures: got %h %h want 0 %h", captured_id, captured_ts, TS); end
    repeat (5) @(negedge clock);
    total++; if (id_mismatch !== 1'b1) begin bad++; $display("FAIL idmm_hold: got %b want 1", id_mismatch); end
  endtask

  task automatic test_waitrequest();
    pulse_start();
    total++; if (id_mismatch !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL start_clears: got mm=%b busy=%b want mm=0 busy=1", id_mismatch, busy); end
    serve(3, ID, TS, 1'b0, 1'b0, 20);
    total++; if (stable_ok !== 1'b1) begin bad++; $display("FAIL wait_stable: got %b want 1", stable_ok); end
    total++; if (done_at !== 10) begin bad++; $display("FAIL wait_latency: got %0d want 10", done_at); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL wait_pass: got %b want 1", pass); end
  endtask

  task automatic test_timeout();
    pulse_start();
    serve(0, ID, TS, 1'b1, 1'b0, 300);
    total++; if (busy_cyc !== 255) begin bad++; $display("FAIL to_cycles: got %0d want 255", busy_cyc); end
    total++; if (done_at !== 255 || read_at_done !== 1'b0) begin
      bad++; $display("FAIL to_done: got at=%0d read=%b want at=255 read=0", done_at, read_at_done); end
    total++; if ({pass, id_mismatch, ts_mismatch, timeout} !== 4'b0001) begin
      bad++; $display("FAIL to_flags: got %b want 0001", {pass, id_mismatch, ts_mismatch, timeout}); end
    total++; if (acc_cnt !== 1) begin bad++; $display("FAIL to_no_ts: got %0d want 1", acc_cnt); end
    avm_readdatavalid = 1'b1; avm_readdata = ID;
    @(negedge clock);
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    total++; if (captured_id !== 32'd0 || busy !== 1'b0 || timeout !== 1'b1) begin
      bad++; $display("FAIL to_stale: got id=%h busy=%b to=%b want 0 0 1", captured_id, busy, timeout); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    serve(0, ID, TS, 1'b0, 1'b1, 20);
    total++; if (acc_cnt !== 2 || done_cnt !== 1) begin
      bad++; $display("FAIL busy_start: got acc=%0d done=%0d want 2 1", acc_cnt, done_cnt); end
  endtask

  task automatic test_reset_midop();
    pulse_start();
    serve(0, ID, TS, 1'b0, 1'b0, 3);
    total++; if (busy !== 1'b1 || captured_id !== ID) begin
      bad++; $display("FAIL wt_ts_pre: got busy=%b id=%h want 1 %h", busy, captured_id, ID); end
    reset = 1'b1;
    #1;
    total++; if ({avm_read, busy, pass, id_mismatch, ts_mismatch, timeout} !== 6'd0 || captured_id !== 32'd0) begin
      bad++; $display("FAIL wt_ts_reset: got %b id=%h want 000000 0",
        {avm_read, busy, pass, id_mismatch, ts_mismatch, timeout}, captured_id); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulse_start();
    serve(5, ID, TS, 1'b0, 1'b0, 2);
    total++; if (avm_read !== 1'b1) begin bad++; $display("FAIL stall_pre: got %b want 1", avm_read); end
    reset = 1'b1;
    #1;
    total++; if (avm_read !== 1'b0) begin bad++; $display("FAIL async_drop: got %b want 0", avm_read); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_auto_start();
    total++; if (done2 !== 1'b0 || avm_read2 !== 1'b0) begin
      bad++; $display("FAIL auto_held: got done=%b read=%b want 0 0", done2, avm_read2); end
    reset2 = 1'b0;
    @(negedge clock);
    total++; if (avm_read2 !== 1'b1 || avm_address2 !== 1'b0) begin
      bad++; $display("FAIL auto_rd_id: got read=%b addr=%b want 1 0", avm_read2, avm_address2); end
    @(negedge clock);
    total++; if (avm_read2 !== 1'b1 || avm_address2 !== 1'b1) begin
      bad++; $display("FAIL auto_rd_ts: got read=%b addr=%b want 1 1", avm_read2, avm_address2); end
    @(negedge clock);
    total++; if ({done2, busy2, pass2, id_mm2, ts_mm2, timeout2} !== 6'b101000) begin
      bad++; $display("FAIL auto_result: got %b want 101000", {done2, busy2, pass2, id_mm2, ts_mm2, timeout2}); end
    total++; if (captured_id2 !== ID || captured_ts2 !== TS) begin
      bad++; $display("FAIL auto_captures: got %h %h want %h %h", captured_id2, captured_ts2, ID, TS); end
    @(negedge clock);
    total++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL auto_once: got done=%b busy=%b want 0 0", done2, busy2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_id_mismatch();
    test_waitrequest();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    test_auto_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
